// File: rtl/weakmem_if.sv
// Request/ack bus between the weakcore master and the weakmem slave.
// The mem_err line exists only when WEAKMEM_ERR_EN is defined.
interface weakmem_if;
  logic        mem_req;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
`ifdef WEAKMEM_ERR_EN
  logic        mem_err;

  modport master (output mem_req, mem_wr, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ack, mem_err);
  modport slave  (input  mem_req, mem_wr, mem_addr, mem_wdata,
                  output mem_rdata, mem_ack, mem_err);
`else
  modport master (output mem_req, mem_wr, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ack);
  modport slave  (input  mem_req, mem_wr, mem_addr, mem_wdata,
                  output mem_rdata, mem_ack);
`endif
endinterface

// File: rtl/weakmem.sv
// Word-organised RAM slave with WAIT_CYCLES of latency between accept and ack.
// Define WEAKMEM_ERR_EN to add mem_err for out-of-range or misaligned accesses.
module weakmem #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input logic      clk,
  input logic      rst,
  weakmem_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t      state;
  logic [7:0]  count;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        lat_wr;
  logic [31:0] rdata_q;
  logic        ack_q;
  logic [31:0] ram [DEPTH_WORDS];

  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        acc_wr;
  logic        fire;
  logic        in_range;
  logic [AW-1:0] idx;

  // With zero wait states the access happens on the accept edge itself,
  // so the bus inputs are used directly instead of the latched copies.
  always_comb begin
    acc_addr  = lat_addr;
    acc_wdata = lat_wdata;
    acc_wr    = lat_wr;
    if (state == IDLE) begin
      acc_addr  = bus.mem_addr;
      acc_wdata = bus.mem_wdata;
      acc_wr    = bus.mem_wr;
    end
  end

  assign fire = rst && (((state == IDLE) && bus.mem_req && (WAIT_CYCLES == 0)) ||
                        ((state == WAIT) && (count == 8'd1)));
  assign in_range = ({2'b00, acc_addr[31:2]} < 32'(DEPTH_WORDS));
  assign idx      = acc_addr[AW+1:2];

  assign bus.mem_rdata = rdata_q;
  assign bus.mem_ack   = ack_q;

`ifdef WEAKMEM_ERR_EN
  logic err_q;
  assign bus.mem_err = err_q;

  always_ff @(posedge clk) begin
    if (!rst)
      err_q <= 1'b0;
    else if (fire)
      err_q <= !in_range || (acc_addr[1:0] != 2'b00);
    else
      err_q <= 1'b0;
  end
`else
  logic unused_low_bits;
  assign unused_low_bits = ^acc_addr[1:0];
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      ack_q   <= 1'b0;
      rdata_q <= 32'h0;
      count   <= 8'd0;
    end else begin
      ack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.mem_req) begin
            lat_addr  <= bus.mem_addr;
            lat_wdata <= bus.mem_wdata;
            lat_wr    <= bus.mem_wr;
            if (WAIT_CYCLES == 0) begin
              state <= ACK;
            end else begin
              state <= WAIT;
              count <= 8'(WAIT_CYCLES);
            end
          end
        end
        WAIT: begin
          count <= count - 8'd1;
          if (count == 8'd1)
            state <= ACK;
        end
        ACK: state <= IDLE;
        default: state <= IDLE;
      endcase
      // Writes return zero; reads outside the RAM return zero too.
      if (fire) begin
        ack_q   <= 1'b1;
        rdata_q <= (!acc_wr && in_range) ? ram[idx] : 32'h0;
      end
    end
  end

  // RAM has no reset so its contents survive rst; fire is already gated by rst.
  always_ff @(posedge clk) begin
    if (fire && acc_wr && in_range)
      ram[idx] <= acc_wdata;
  end

endmodule

// File: tb/tb_weakmem.sv
// Randomised self-checking bench for weakmem against an array-based memory model.
// A second instance covers the zero-wait-state configuration.
module tb_weakmem;

  localparam int DEPTH = 1024;
  localparam int WAIT  = 2;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [31:0] model_mem [DEPTH];

  weakmem_if bus ();
  weakmem_if bus0 ();

  weakmem #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  weakmem #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the slave idle; returns at a negedge with it idle again.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input bit scramble,
                               input string tag);
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        in_range;
    bit          hit;
    in_range  = (addr[31:2] < 30'(DEPTH));
    exp_err   = !in_range || (addr[1:0] != 2'b00);
    exp_rdata = (!wr && in_range) ? model_mem[addr[11:2]] : 32'h0;
    if (wr && in_range)
      model_mem[addr[11:2]] = wdata;

    bus.mem_req   = 1'b1;
    bus.mem_wr    = wr;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    @(posedge clk);
    #1;
    if (scramble) begin
      bus.mem_addr  = {20'h0, 5'($urandom_range(0, 31)), 2'b00} ^ 32'h40;
      bus.mem_wdata = $urandom;
    end
    hit = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.mem_ack) begin
        hit = 1;
        checkOutput({tag, "_latency"}, 32'(i), 32'(WAIT));
        checkOutput({tag, "_rdata"}, bus.mem_rdata, exp_rdata);
`ifdef WEAKMEM_ERR_EN
        checkOutput({tag, "_err"}, 32'(bus.mem_err), 32'(exp_err));
`endif
        break;
      end
    end
    if (!hit)
      checkOutput({tag, "_ack_timeout"}, 32'h0, 32'h1);
    bus.mem_req = 1'b0;
    @(posedge clk);
    #1;
    checkOutput({tag, "_ack_single"}, 32'(bus.mem_ack), 32'h0);
    checkOutput({tag, "_rdata_hold"}, bus.mem_rdata, exp_rdata);
    @(negedge clk);
  endtask

  logic        z_wr   [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [31:0] z_addr [5] = '{32'h0, 32'h4, 32'h0, 32'h4, 32'h40};
  logic [31:0] z_data [5] = '{32'h0F0F0001, 32'h0F0F0002, 32'h0, 32'h0, 32'h0};
  logic [31:0] z_exp  [5] = '{32'h0, 32'h0, 32'h0F0F0001, 32'h0F0F0002, 32'h0};

  initial begin
    logic        r_wr;
    logic [31:0] r_addr;
    rst            = 1'b0;
    bus.mem_req    = 1'b1;
    bus.mem_wr     = 1'b1;
    bus.mem_addr   = 32'h0;
    bus.mem_wdata  = 32'hBAD0BAD0;
    bus0.mem_req   = 1'b0;
    bus0.mem_wr    = 1'b0;
    bus0.mem_addr  = 32'h0;
    bus0.mem_wdata = 32'h0;

    // Reset held with a request pending: nothing may be acknowledged.
    repeat (3) begin
      @(negedge clk);
      checkOutput("reset_ack", 32'(bus.mem_ack), 32'h0);
      checkOutput("reset_rdata", bus.mem_rdata, 32'h0);
    end
    rst = 1'b1;
    applyStimulus(1'b1, 32'h0, 32'h11111111, 0, "post_reset");

    for (int w = 1; w < 32; w++)
      applyStimulus(1'b1, 32'(w * 4), $urandom, 0, "init");

    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 0, "sw_10");
    applyStimulus(1'b0, 32'h10, 32'h0, 0, "lw_10");

    applyStimulus(1'b1, 32'h1000, 32'h12345678, 0, "oor_sw");
    applyStimulus(1'b0, 32'h0, 32'h0, 0, "oor_ram0");
    applyStimulus(1'b0, 32'h1000, 32'h0, 0, "oor_lw");

    // Reset during WAIT must drop the pending write.
    bus.mem_req   = 1'b1;
    bus.mem_wr    = 1'b1;
    bus.mem_addr  = 32'h20;
    bus.mem_wdata = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    bus.mem_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst_ack", 32'(bus.mem_ack), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      checkOutput("midrst_noack", 32'(bus.mem_ack), 32'h0);
    end
    @(negedge clk);
    applyStimulus(1'b0, 32'h20, 32'h0, 0, "midrst_lw");

    applyStimulus(1'b1, 32'h30, 32'hCAFEF00D, 1, "latched_sw");
    applyStimulus(1'b0, 32'h30, 32'h0, 0, "latched_lw");

    for (int n = 0; n < 60; n++) begin
      r_wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0)
        r_addr = $urandom | 32'h0000_1000;
      else
        r_addr = {20'h0, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3) == 0 ? $urandom : 0)};
      applyStimulus(r_wr, r_addr, $urandom, 0, "random");
    end

    // Zero wait states, request held high throughout.
    bus0.mem_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus0.mem_wr    = z_wr[i];
      bus0.mem_addr  = z_addr[i];
      bus0.mem_wdata = z_data[i];
      @(posedge clk);
      #1;
      checkOutput("zero_ack", 32'(bus0.mem_ack), 32'h1);
      checkOutput("zero_rdata", bus0.mem_rdata, z_exp[i]);
      @(posedge clk);
      #1;
      checkOutput("zero_gap", 32'(bus0.mem_ack), 32'h0);
      @(negedge clk);
    end
    bus0.mem_req = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
